// File: rtl/machine_mode_types_1_12_pkg.sv
// Privileged-architecture 1.12 types: CSR address and privilege level encodings.
package machine_mode_types_1_12_pkg;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [1:0] {
    U_MODE = 2'b00,
    S_MODE = 2'b01,
    H_MODE = 2'b10,
    M_MODE = 2'b11
  } priv_level_t;

endpackage

// File: rtl/rv32i_types_pkg.sv
// RV32I/Zicsr encodings shared by the CSR request path: funct3 values and the
// request FSM state type.
package rv32i_types_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } csr_req_state_t;

endpackage

// File: rtl/priv_1_12_csr_legal_chk.sv
// Combinational legality check for a Zicsr access: decides write intent and
// whether the access must trap as illegal.
module priv_1_12_csr_legal_chk
  import rv32i_types_pkg::*;
  import machine_mode_types_1_12_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [3:0]  i_addr_hi,
  input  logic [4:0]  i_rs1_idx,
  input  priv_level_t i_priv,
  input  logic        i_invalid_csr,
  output logic        o_write_intent,
  output logic        o_illegal
);

  logic       w_bad_funct3;
  logic       w_priv_low;
  logic       w_ro_write;
  logic [1:0] w_priv;

  // Set/clear forms with x0/zimm=0 are pure reads and must not touch the CSR.
  always_comb begin
    o_write_intent = 1'b0;
    w_bad_funct3   = 1'b0;
    case (i_funct3)
      F3_CSRRW, F3_CSRRWI: o_write_intent = 1'b1;
      F3_CSRRS, F3_CSRRC,
      F3_CSRRSI, F3_CSRRCI: o_write_intent = (i_rs1_idx != 5'd0);
      default:             w_bad_funct3   = 1'b1;
    endcase
  end

  assign w_priv      = i_priv;
  assign w_priv_low  = (i_addr_hi[1:0] > w_priv);
  assign w_ro_write  = o_write_intent && (i_addr_hi[3:2] == 2'b11);
  assign o_illegal   = w_bad_funct3 | i_invalid_csr | w_priv_low | w_ro_write;

endmodule

// File: rtl/priv_1_12_csr_req_ctrl.sv
// CSR instruction sequencer: accepts a Zicsr request, checks legality against the
// CSR file, issues at most one write/set/clear strobe and returns the old value.
module priv_1_12_csr_req_ctrl
  import rv32i_types_pkg::*;
  import machine_mode_types_1_12_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  csr_addr_t   req_addr,
  input  logic [31:0] req_rs1_val,
  input  logic [4:0]  req_rs1_idx,
  input  logic [4:0]  req_rd_idx,
  input  priv_level_t req_priv,
  input  logic        flush,
  output csr_addr_t   csr_addr,
  output priv_level_t curr_priv,
  output logic        csr_write,
  output logic        csr_set,
  output logic        csr_clear,
  output logic [31:0] new_csr_val,
  input  logic [31:0] old_csr_val,
  input  logic        invalid_csr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_illegal,
  output logic [4:0]  resp_rd_idx
);

  csr_req_state_t r_state;
  logic [2:0]     r_funct3;
  csr_addr_t      r_addr;
  logic [31:0]    r_rs1_val;
  logic [4:0]     r_rs1_idx;
  logic [4:0]     r_rd_idx;
  priv_level_t    r_priv;
  logic [31:0]    r_old_val;
  logic           r_req_ready;
  logic           r_resp_valid;
  logic           r_csr_write;
  logic           r_csr_set;
  logic           r_csr_clear;
  logic [31:0]    r_resp_rdata;
  logic           r_resp_illegal;
  logic [4:0]     r_resp_rd_idx;

  logic           w_illegal;
  logic           w_write_intent;
  logic [31:0]    w_operand;

  priv_1_12_csr_legal_chk u_legal_chk (
    .i_funct3       (r_funct3),
    .i_addr_hi      (r_addr[11:8]),
    .i_rs1_idx      (r_rs1_idx),
    .i_priv         (r_priv),
    .i_invalid_csr  (invalid_csr),
    .o_write_intent (w_write_intent),
    .o_illegal      (w_illegal)
  );

  assign w_operand = r_funct3[2] ? {27'd0, r_rs1_idx} : r_rs1_val;

  // Strobes are set only on the CHECK->COMMIT edge, so they live for exactly one cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state        <= ST_IDLE;
      r_funct3       <= 3'd0;
      r_addr         <= '0;
      r_rs1_val      <= 32'd0;
      r_rs1_idx      <= 5'd0;
      r_rd_idx       <= 5'd0;
      r_priv         <= U_MODE;
      r_old_val      <= 32'd0;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_csr_write    <= 1'b0;
      r_csr_set      <= 1'b0;
      r_csr_clear    <= 1'b0;
      r_resp_rdata   <= 32'd0;
      r_resp_illegal <= 1'b0;
      r_resp_rd_idx  <= 5'd0;
    end else begin
      r_csr_write <= 1'b0;
      r_csr_set   <= 1'b0;
      r_csr_clear <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_rs1_val   <= req_rs1_val;
            r_rs1_idx   <= req_rs1_idx;
            r_rd_idx    <= req_rd_idx;
            r_priv      <= req_priv;
            r_req_ready <= 1'b0;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          r_old_val <= old_csr_val;
          if (flush) begin
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_illegal) begin
            r_resp_valid   <= 1'b1;
            r_resp_rdata   <= 32'd0;
            r_resp_illegal <= 1'b1;
            r_resp_rd_idx  <= r_rd_idx;
            r_state        <= ST_RESP;
          end else begin
            if (w_write_intent) begin
              case (r_funct3[1:0])
                2'b01:   r_csr_write <= 1'b1;
                2'b10:   r_csr_set   <= 1'b1;
                2'b11:   r_csr_clear <= 1'b1;
                default: r_csr_write <= 1'b0;
              endcase
            end
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= r_old_val;
          r_resp_illegal <= 1'b0;
          r_resp_rd_idx  <= r_rd_idx;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (flush || resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign csr_addr     = r_addr;
  assign curr_priv    = r_priv;
  assign csr_write    = r_csr_write;
  assign csr_set      = r_csr_set;
  assign csr_clear    = r_csr_clear;
  assign new_csr_val  = w_operand;
  assign resp_valid   = r_resp_valid;
  assign resp_rdata   = r_resp_rdata;
  assign resp_illegal = r_resp_illegal;
  assign resp_rd_idx  = r_resp_rd_idx;

endmodule

// File: tb/tb_priv_1_12_csr_req_ctrl.sv
// Bench for the CSR request sequencer: directed vector table, random requests
// against a rule-level model, and a reset-during-commit sequence.
module tb_priv_1_12_csr_req_ctrl;
  import machine_mode_types_1_12_pkg::*;

  localparam int WIN = 10;

  typedef struct {
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [31:0] rs1Val;
    logic [4:0]  rs1Idx;
    logic [4:0]  rdIdx;
    logic [1:0]  priv;
    logic [31:0] oldVal;
    logic        invalid;
    int          hold;
    int          flushAt;
  } txn_t;

  typedef struct {
    logic [2:0]  mask;
    logic        illegal;
    logic [31:0] rdata;
  } tbl_exp_t;

  typedef struct {
    txn_t     t;
    tbl_exp_t x;
  } vector_t;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] newVal;
    int          respStart;
    int          respCycles;
    int          busyEnd;
    logic [31:0] rdata;
    logic        illegal;
    logic [4:0]  rdIdx;
  } exp_t;

  logic        CLK;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_val;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  priv_level_t req_priv;
  logic        flush;
  logic [11:0] csr_addr;
  priv_level_t curr_priv;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic [31:0] new_csr_val;
  logic [31:0] old_csr_val;
  logic        invalid_csr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic [4:0]  resp_rd_idx;

  int checkCount = 0;
  int errorCount = 0;
  int txnId = 0;

  priv_1_12_csr_req_ctrl dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_rs1_val  (req_rs1_val),
    .req_rs1_idx  (req_rs1_idx),
    .req_rd_idx   (req_rd_idx),
    .req_priv     (req_priv),
    .flush        (flush),
    .csr_addr     (csr_addr),
    .curr_priv    (curr_priv),
    .csr_write    (csr_write),
    .csr_set      (csr_set),
    .csr_clear    (csr_clear),
    .new_csr_val  (new_csr_val),
    .old_csr_val  (old_csr_val),
    .invalid_csr  (invalid_csr),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_illegal (resp_illegal),
    .resp_rd_idx  (resp_rd_idx)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s (txn %0d): got 0x%0h, expected 0x%0h", name, txnId, act, exp);
    end
  endtask

  // Reference behaviour from the instruction rules: cycle offsets are counted
  // from the edge that accepts the request.
  function automatic exp_t modelTxn(input txn_t t);
    exp_t e;
    bit   f3Ok;
    bit   writes;
    bit   legal;
    bit   killed;
    int   respEnd;
    f3Ok   = !(t.funct3 == 3'd0 || t.funct3 == 3'd4);
    writes = (t.funct3[1:0] == 2'b01) || (t.rs1Idx != 5'd0);
    legal  = f3Ok && !t.invalid && (t.addr[9:8] <= t.priv) &&
             !(writes && t.addr[11:10] == 2'b11);
    killed = (t.flushAt == 1);
    e.mask = 3'b000;
    if (legal && writes && !killed) begin
      case (t.funct3[1:0])
        2'b01:   e.mask = 3'b001;
        2'b10:   e.mask = 3'b010;
        default: e.mask = 3'b100;
      endcase
    end
    e.newVal  = t.funct3[2] ? 32'(t.rs1Idx) : t.rs1Val;
    e.rdata   = legal ? t.oldVal : 32'd0;
    e.illegal = !legal;
    e.rdIdx   = t.rdIdx;
    if (killed) begin
      e.respStart  = 0;
      e.respCycles = 0;
      e.busyEnd    = 1;
    end else begin
      e.respStart = legal ? 3 : 2;
      respEnd     = e.respStart + t.hold;
      if (t.flushAt >= e.respStart && t.flushAt < respEnd) respEnd = t.flushAt;
      e.respCycles = respEnd - e.respStart + 1;
      e.busyEnd    = respEnd;
    end
    return e;
  endfunction

  task automatic applyStimulus(input txn_t t, input exp_t e);
    logic [2:0]  strobes;
    logic [2:0]  maskSeen = 3'b000;
    int          strobeCycles = 0;
    int          strobeAt = 0;
    logic [31:0] newValSeen = 32'd0;
    logic [11:0] strobeAddr = 12'd0;
    int          respFirst = 0;
    int          respCycles = 0;
    logic [31:0] pRdata = 32'd0;
    logic        pIllegal = 1'b0;
    logic [4:0]  pRd = 5'd0;
    logic        unstable = 1'b0;
    int          readyCycles = 0;
    txnId++;
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_funct3  = t.funct3;
    req_addr    = t.addr;
    req_rs1_val = t.rs1Val;
    req_rs1_idx = t.rs1Idx;
    req_rd_idx  = t.rdIdx;
    req_priv    = priv_level_t'(t.priv);
    old_csr_val = ~t.oldVal;
    invalid_csr = 1'b0;
    flush       = 1'b0;
    resp_ready  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    req_valid   = 1'b0;
    req_addr    = ~t.addr;
    req_rs1_val = ~t.rs1Val;
    req_rs1_idx = ~t.rs1Idx;
    req_rd_idx  = ~t.rdIdx;
    for (int k = 1; k <= WIN; k++) begin
      if (k == 1) begin
        checkOutput("check_csr_addr", 32'(csr_addr), 32'(t.addr));
        checkOutput("check_curr_priv", 32'(curr_priv), 32'(t.priv));
      end
      strobes = {csr_clear, csr_set, csr_write};
      if (strobes != 3'b000) begin
        if (strobeCycles == 0) begin
          strobeAt   = k;
          newValSeen = new_csr_val;
          strobeAddr = csr_addr;
        end
        strobeCycles++;
        maskSeen |= strobes;
      end
      if (resp_valid) begin
        if (respCycles == 0) begin
          respFirst = k;
          pRdata    = resp_rdata;
          pIllegal  = resp_illegal;
          pRd       = resp_rd_idx;
        end else if (resp_rdata !== pRdata || resp_illegal !== pIllegal || resp_rd_idx !== pRd) begin
          unstable = 1'b1;
        end
        respCycles++;
      end
      if (req_ready) readyCycles++;
      old_csr_val = (k == 1) ? t.oldVal : ~t.oldVal;
      invalid_csr = (k == 1) ? t.invalid : 1'b0;
      flush       = (k == t.flushAt);
      resp_ready  = (e.respStart != 0) && (k >= e.respStart + t.hold);
      @(posedge CLK);
      @(negedge CLK);
    end
    flush      = 1'b0;
    resp_ready = 1'b0;
    checkOutput("strobe_mask", 32'(maskSeen), 32'(e.mask));
    checkOutput("strobe_cycles", 32'(strobeCycles), (e.mask != 3'b000) ? 32'd1 : 32'd0);
    if (e.mask != 3'b000) begin
      checkOutput("strobe_cycle", 32'(strobeAt), 32'd2);
      checkOutput("new_csr_val", newValSeen, e.newVal);
      checkOutput("strobe_addr", 32'(strobeAddr), 32'(t.addr));
    end
    checkOutput("resp_start", 32'(respFirst), 32'(e.respStart));
    checkOutput("resp_cycles", 32'(respCycles), 32'(e.respCycles));
    if (e.respStart != 0) begin
      checkOutput("resp_rdata", pRdata, e.rdata);
      checkOutput("resp_illegal", 32'(pIllegal), 32'(e.illegal));
      checkOutput("resp_rd_idx", 32'(pRd), 32'(e.rdIdx));
      checkOutput("resp_stable", 32'(unstable), 32'd0);
    end
    checkOutput("req_ready_cycles", 32'(readyCycles), 32'(WIN - e.busyEnd));
  endtask

  function automatic vector_t mkVec(input logic [2:0] f3, input logic [11:0] addr,
                                    input logic [31:0] rs1Val, input logic [4:0] rs1Idx,
                                    input logic [4:0] rd, input logic [1:0] priv,
                                    input logic [31:0] oldVal, input logic inv,
                                    input int hold, input int flushAt, input logic [2:0] xMask,
                                    input logic xIll, input logic [31:0] xRdata);
    vector_t v;
    v.t = '{funct3: f3, addr: addr, rs1Val: rs1Val, rs1Idx: rs1Idx, rdIdx: rd, priv: priv,
            oldVal: oldVal, invalid: inv, hold: hold, flushAt: flushAt};
    v.x = '{mask: xMask, illegal: xIll, rdata: xRdata};
    return v;
  endfunction

  vector_t vecs[$];

  initial begin
    txn_t        t;
    exp_t        e;
    logic [2:0]  strobes;
    int          badStrobe;
    int          badResp;
    nRST        = 1'b1;
    req_valid   = 1'b0;
    req_funct3  = 3'd0;
    req_addr    = 12'd0;
    req_rs1_val = 32'd0;
    req_rs1_idx = 5'd0;
    req_rd_idx  = 5'd0;
    req_priv    = U_MODE;
    flush       = 1'b0;
    old_csr_val = 32'd0;
    invalid_csr = 1'b0;
    resp_ready  = 1'b0;
    #2 nRST = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_strobes", 32'({csr_clear, csr_set, csr_write}), 32'd0);
    checkOutput("rst_resp_payload", resp_rdata | 32'(resp_illegal) | 32'(resp_rd_idx), 32'd0);
    checkOutput("rst_captured", 32'(csr_addr) | new_csr_val, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);

    vecs.push_back(mkVec(3'b001, 12'h340, 32'hDEADBEEF, 5'd7,  5'd3,  2'b11, 32'h12345678, 1'b0, 0, 0, 3'b001, 1'b0, 32'h12345678));
    vecs.push_back(mkVec(3'b010, 12'h300, 32'hFFFFFFFF, 5'd0,  5'd4,  2'b11, 32'hAAAA5555, 1'b0, 0, 0, 3'b000, 1'b0, 32'hAAAA5555));
    vecs.push_back(mkVec(3'b101, 12'hF14, 32'h0,        5'd5,  5'd6,  2'b11, 32'h0000CAFE, 1'b0, 0, 0, 3'b000, 1'b1, 32'h0));
    vecs.push_back(mkVec(3'b010, 12'h300, 32'h8,        5'd4,  5'd1,  2'b00, 32'h00001800, 1'b0, 0, 0, 3'b000, 1'b1, 32'h0));
    vecs.push_back(mkVec(3'b011, 12'h341, 32'h00000F0F, 5'd9,  5'd2,  2'b11, 32'h00001111, 1'b0, 0, 0, 3'b100, 1'b0, 32'h00001111));
    vecs.push_back(mkVec(3'b110, 12'h100, 32'hFFFF0000, 5'd31, 5'd8,  2'b01, 32'h00000022, 1'b0, 0, 0, 3'b010, 1'b0, 32'h00000022));
    vecs.push_back(mkVec(3'b111, 12'hF11, 32'h0,        5'd0,  5'd9,  2'b11, 32'h00000005, 1'b0, 0, 0, 3'b000, 1'b0, 32'h00000005));
    vecs.push_back(mkVec(3'b000, 12'h340, 32'h1,        5'd1,  5'd10, 2'b11, 32'h00000077, 1'b0, 0, 0, 3'b000, 1'b1, 32'h0));
    vecs.push_back(mkVec(3'b100, 12'h340, 32'h1,        5'd1,  5'd11, 2'b11, 32'h00000077, 1'b0, 0, 0, 3'b000, 1'b1, 32'h0));
    vecs.push_back(mkVec(3'b001, 12'h7C0, 32'h55,       5'd2,  5'd12, 2'b11, 32'h00000099, 1'b1, 0, 0, 3'b000, 1'b1, 32'h0));
    vecs.push_back(mkVec(3'b001, 12'h340, 32'h0BADF00D, 5'd3,  5'd13, 2'b11, 32'h13572468, 1'b0, 4, 0, 3'b001, 1'b0, 32'h13572468));
    vecs.push_back(mkVec(3'b001, 12'h340, 32'h0BADF00D, 5'd3,  5'd14, 2'b11, 32'h13572468, 1'b0, 0, 1, 3'b000, 1'b0, 32'h0));
    vecs.push_back(mkVec(3'b010, 12'h300, 32'h00000008, 5'd2,  5'd15, 2'b11, 32'h00001888, 1'b0, 0, 2, 3'b010, 1'b0, 32'h00001888));
    vecs.push_back(mkVec(3'b001, 12'h340, 32'h00000042, 5'd6,  5'd16, 2'b11, 32'h00000314, 1'b0, 3, 3, 3'b001, 1'b0, 32'h00000314));
    vecs.push_back(mkVec(3'b001, 12'hC00, 32'h00000001, 5'd1,  5'd17, 2'b00, 32'h00000123, 1'b0, 0, 0, 3'b000, 1'b1, 32'h0));

    foreach (vecs[i]) begin
      e         = modelTxn(vecs[i].t);
      e.mask    = vecs[i].x.mask;
      e.illegal = vecs[i].x.illegal;
      e.rdata   = vecs[i].x.rdata;
      applyStimulus(vecs[i].t, e);
    end

    for (int i = 0; i < 80; i++) begin
      t.funct3  = 3'($urandom);
      t.addr    = 12'($urandom);
      t.rs1Val  = $urandom;
      t.rs1Idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      t.rdIdx   = 5'($urandom);
      t.priv    = 2'($urandom);
      t.oldVal  = $urandom;
      t.invalid = ($urandom_range(0, 7) == 0);
      t.hold    = int'($urandom_range(0, 3));
      t.flushAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      applyStimulus(t, modelTxn(t));
    end

    // Reset pulse while the write strobe is live must kill it at once.
    txnId++;
    req_valid   = 1'b1;
    req_funct3  = 3'b001;
    req_addr    = 12'h340;
    req_rs1_val = 32'hFEEDFACE;
    req_rs1_idx = 5'd4;
    req_rd_idx  = 5'd5;
    req_priv    = M_MODE;
    @(posedge CLK);
    @(negedge CLK);
    req_valid   = 1'b0;
    old_csr_val = 32'h0000ABCD;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("commit_write_before_reset", 32'(csr_write), 32'd1);
    #1 nRST = 1'b0;
    #1;
    checkOutput("reset_strobes_drop", 32'({csr_clear, csr_set, csr_write}), 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_csr_addr", 32'(csr_addr), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    badStrobe = 0;
    badResp   = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      strobes = {csr_clear, csr_set, csr_write};
      if (strobes != 3'b000) badStrobe++;
      if (resp_valid) badResp++;
    end
    checkOutput("post_reset_strobes", 32'(badStrobe), 32'd0);
    checkOutput("post_reset_resp", 32'(badResp), 32'd0);
    checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
